// File: rtl/eth_tx_scheduler.sv
// Round-robin scheduler sharing one Ethernet transmitter among N_REQ frame sources.
// Optional statistics ports (frame_cnt, err_cnt) are added when TX_SCHED_STATS_EN is defined.
module eth_tx_scheduler #(
  parameter int N_REQ      = 4,
  parameter int IFG_CYCLES = 96,
  parameter int START_TMO  = 16,
  parameter int FRAME_TMO  = 65535,
  localparam int SEL_W     = $clog2(N_REQ)
) (
  input  logic                 clk_100_mhz,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*11-1:0]  req_count,
  input  logic [N_REQ-1:0]     req_fcs_calc,
  input  logic                 tx_busy,
  output logic [31:0]          signals,
  output logic [SEL_W-1:0]     sel,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done,
  output logic [N_REQ-1:0]     err
`ifdef TX_SCHED_STATS_EN
  ,
  output logic [31:0]          frame_cnt,
  output logic [15:0]          err_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_IFG
  } state_t;

  localparam logic [15:0] START_LIM = 16'(START_TMO - 1);
  localparam logic [15:0] FRAME_LIM = 16'(FRAME_TMO - 1);
  localparam logic [15:0] IFG_LIM   = 16'(IFG_CYCLES - 1);

  state_t              r_state;
  logic [SEL_W-1:0]    r_rr;
  logic [15:0]         r_cnt;
  logic [31:0]         r_signals;
  logic [SEL_W-1:0]    r_sel;
  logic [N_REQ-1:0]    r_grant;
  logic [N_REQ-1:0]    r_done;
  logic [N_REQ-1:0]    r_err;

  logic                w_found;
  logic [SEL_W-1:0]    w_winner;
  logic [SEL_W-1:0]    w_cand;
  logic [15:0]         w_cnt_inc;

  // Search starts at the rr pointer and wraps, so the first hit is the round-robin winner.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = SEL_W'((int'(r_rr) + k) % N_REQ);
      if (!w_found && req[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

  // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
  always_ff @(posedge clk_100_mhz or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rr      <= '0;
      r_cnt     <= '0;
      r_signals <= '0;
      r_sel     <= '0;
      r_grant   <= '0;
      r_done    <= '0;
      r_err     <= '0;
    end else begin
      r_done <= '0;
      r_err  <= '0;
      case (r_state)
        S_IDLE: begin
          if (|req) r_state <= S_ARB;
        end
        S_ARB: begin
          if (w_found) begin
            r_grant   <= N_REQ'(1) << w_winner;
            r_sel     <= w_winner;
            r_signals <= {19'd0, req_count[int'(w_winner)*11 +: 11], req_fcs_calc[w_winner], 1'b1};
            r_rr      <= (w_winner == SEL_W'(N_REQ - 1)) ? '0 : w_winner + 1'b1;
            r_state   <= S_START;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_START: begin
          r_signals[0] <= 1'b0;
          r_cnt        <= '0;
          r_state      <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (tx_busy) begin
            r_cnt   <= '0;
            r_state <= S_WAIT_DONE;
          end else if (r_cnt >= START_LIM) begin
            r_err     <= r_grant;
            r_signals <= '0;
            r_cnt     <= '0;
            r_state   <= S_IFG;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_WAIT_DONE: begin
          // Grant stays up for the pulse cycle and is dropped on the first IFG edge.
          if (!tx_busy) begin
            r_done    <= r_grant;
            r_signals <= '0;
            r_cnt     <= '0;
            r_state   <= S_IFG;
          end else if (r_cnt >= FRAME_LIM) begin
            r_err     <= r_grant;
            r_signals <= '0;
            r_cnt     <= '0;
            r_state   <= S_IFG;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_IFG: begin
          r_grant <= '0;
          r_sel   <= '0;
          if (tx_busy) begin
            r_cnt <= '0;
          end else if (r_cnt >= IFG_LIM) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign signals = r_signals;
  assign sel     = r_sel;
  assign grant   = r_grant;
  assign done    = r_done;
  assign err     = r_err;

`ifdef TX_SCHED_STATS_EN
  logic [31:0] r_frame_cnt;
  logic [15:0] r_err_cnt;

  // Frame count wraps naturally; error count saturates.
  always_ff @(posedge clk_100_mhz or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (|r_done) r_frame_cnt <= r_frame_cnt + 32'd1;
      if (|r_err && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;
`endif

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Self-checking bench for eth_tx_scheduler: randomized traffic against a round-robin reference model.
module tb_eth_tx_scheduler;

  localparam int N_REQ      = 4;
  localparam int IFG_CYCLES = 96;
  localparam int START_TMO  = 16;
  localparam int FRAME_TMO  = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [43:0] req_count = '0;
  logic [3:0]  req_fcs_calc = '0;
  logic        tx_busy = 1'b0;
  logic [31:0] signals;
  logic [1:0]  sel;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [3:0]  err;
`ifdef TX_SCHED_STATS_EN
  logic [31:0] frame_cnt;
  logic [15:0] err_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int m_rr     = 0;
  logic [10:0] m_count [4];

  eth_tx_scheduler #(
    .N_REQ(N_REQ), .IFG_CYCLES(IFG_CYCLES), .START_TMO(START_TMO), .FRAME_TMO(FRAME_TMO)
  ) dut (
    .clk_100_mhz (clk),
    .rst         (rst),
    .req         (req),
    .req_count   (req_count),
    .req_fcs_calc(req_fcs_calc),
    .tx_busy     (tx_busy),
    .signals     (signals),
    .sel         (sel),
    .grant       (grant),
    .done        (done),
    .err         (err)
`ifdef TX_SCHED_STATS_EN
    ,
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rr_pick(input logic [3:0] pend, input int ptr);
    for (int k = 0; k < 4; k++) if (pend[(ptr + k) % 4]) return 4'(1 << ((ptr + k) % 4));
    return 4'b0000;
  endfunction

  function automatic int oh_idx(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return 0;
  endfunction

  task automatic apply_counts();
    for (int i = 0; i < 4; i++) req_count[11*i +: 11] = m_count[i];
  endtask

  task automatic randomize_counts();
    for (int i = 0; i < 4; i++) m_count[i] = 11'($urandom_range(0, 2047));
    req_fcs_calc = 4'($urandom);
    apply_counts();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_rr = 0;
  endtask

  // Waits for the start pulse, checks the granted word, drives busy for len cycles, checks done.
  task automatic serve_frame(input logic [3:0] exp_oh, input int dly, input int len,
                             input string tag, output int waited);
    int w; bit seen; bit stray; int e; logic [31:0] exp_sig;
    w = 0; seen = 1'b0; stray = 1'b0;
    e = oh_idx(exp_oh);
    exp_sig = {19'd0, m_count[e], req_fcs_calc[e], 1'b1};
    while (!seen && w < 400) begin
      @(negedge clk); w++;
      seen = (signals[0] === 1'b1);
    end
    waited = w;
    n_checks++;
    if (!seen) begin
      $display("FAIL %s_start: got no start pulse in %0d cycles, need one", tag, w);
      return;
    end
    n_pass++;
    n_checks++;
    if ({grant, sel} !== {exp_oh, 2'(e)})
      $display("FAIL %s_grant: got grant=%b sel=%0d, need grant=%b sel=%0d", tag, grant, sel, exp_oh, e);
    else n_pass++;
    n_checks++;
    if (signals !== exp_sig) $display("FAIL %s_signals: got %h, need %h", tag, signals, exp_sig);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (signals !== {exp_sig[31:1], 1'b0})
      $display("FAIL %s_held: got %h, need %h", tag, signals, {exp_sig[31:1], 1'b0});
    else n_pass++;
    repeat (dly - 1) @(negedge clk);
    tx_busy = 1'b1;
    repeat (len) begin
      @(negedge clk);
      if (done !== 4'b0 || err !== 4'b0) stray = 1'b1;
    end
    tx_busy = 1'b0;
    n_checks++;
    if (stray) $display("FAIL %s_early_pulse: got done/err during busy, need none", tag);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({done, err, grant} !== {exp_oh, 4'b0, exp_oh})
      $display("FAIL %s_done: got done=%b err=%b grant=%b, need done=%b err=0000 grant=%b",
               tag, done, err, grant, exp_oh, exp_oh);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({done, err, grant, signals} !== 44'd0)
      $display("FAIL %s_ifg_clear: got done=%b grant=%b signals=%h, need all zero", tag, done, grant, signals);
    else n_pass++;
    m_rr = (e + 1) % 4;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({signals, sel, grant, done, err} !== 46'd0)
      $display("FAIL reset_outputs: got signals=%h sel=%0d grant=%b done=%b err=%b, need all zero",
               signals, sel, grant, done, err);
    else n_pass++;
  endtask

  task automatic test_single();
    int w;
    do_reset();
    randomize_counts();
    m_count[0] = 11'd64; req_fcs_calc[0] = 1'b1;
    apply_counts();
    req = 4'b0001;
    serve_frame(rr_pick(req, m_rr), 3, 100, "single", w);
    n_checks++;
    if (w !== 2) $display("FAIL single_latency: got %0d cycles, need 2", w);
    else n_pass++;
    serve_frame(rr_pick(req, m_rr), 2, 10, "single2", w);
    n_checks++;
    if (w + 2 < IFG_CYCLES || w + 2 > IFG_CYCLES + 3)
      $display("FAIL single_ifg: got %0d cycles busy-fall to start, need %0d..%0d", w + 2, IFG_CYCLES, IFG_CYCLES + 3);
    else n_pass++;
    req = '0;
  endtask

  task automatic test_round_robin();
    int w;
    do_reset();
    randomize_counts();
    m_count[1] = 11'd0; m_count[2] = 11'd2047;
    apply_counts();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) serve_frame(rr_pick(req, m_rr), 1 + (i % 3), 5 + i, "rr", w);
    req = '0;
  endtask

  task automatic test_random();
    int w; logic [3:0] win; int wi;
    do_reset();
    randomize_counts();
    req = 4'($urandom_range(1, 15));
    for (int i = 0; i < 14; i++) begin
      win = rr_pick(req, m_rr);
      serve_frame(win, $urandom_range(1, 5), $urandom_range(1, 30), "rand", w);
      wi = oh_idx(win);
      if ($urandom_range(0, 1) == 1) req[wi] = 1'b0;
      m_count[wi] = 11'($urandom_range(0, 2047));
      for (int j = 0; j < 4; j++) if (j != wi && $urandom_range(0, 2) == 0) req[j] = 1'b1;
      if (req == 4'b0) req = 4'($urandom_range(1, 15));
      apply_counts();
    end
    req = '0;
  endtask

  task automatic test_start_timeout();
    int w; int c; bit stray;
    do_reset();
    randomize_counts();
    req = 4'b0100;
    w = 0;
    while (signals[0] !== 1'b1 && w < 10) begin @(negedge clk); w++; end
    m_rr = 3;
    c = 0; stray = 1'b0;
    while (err === 4'b0 && c < 40) begin
      @(negedge clk); c++;
      if (done !== 4'b0) stray = 1'b1;
    end
    n_checks++;
    if ({err, grant} !== {4'b0100, 4'b0100})
      $display("FAIL start_tmo_err: got err=%b grant=%b, need err=0100 grant=0100", err, grant);
    else n_pass++;
    n_checks++;
    if (c < START_TMO || c > START_TMO + 3)
      $display("FAIL start_tmo_time: got err after %0d cycles, need %0d..%0d", c, START_TMO, START_TMO + 3);
    else n_pass++;
    n_checks++;
    if (stray) $display("FAIL start_tmo_done: got done pulse, need none");
    else n_pass++;
    req = 4'b0000;
    @(negedge clk);
    n_checks++;
    if ({grant, signals, err} !== 40'd0)
      $display("FAIL start_tmo_ifg: got grant=%b signals=%h err=%b, need zero", grant, signals, err);
    else n_pass++;
    req = 4'b0010;
    serve_frame(rr_pick(req, m_rr), 2, 8, "after_tmo", w);
    n_checks++;
    if (w + 1 < IFG_CYCLES || w + 1 > IFG_CYCLES + 3)
      $display("FAIL start_tmo_gap: got %0d cycles err to start, need %0d..%0d", w + 1, IFG_CYCLES, IFG_CYCLES + 3);
    else n_pass++;
    req = '0;
  endtask

  task automatic test_frame_timeout();
    int w; int c; bit stray;
    do_reset();
    randomize_counts();
    req = 4'b0001;
    w = 0;
    while (signals[0] !== 1'b1 && w < 10) begin @(negedge clk); w++; end
    m_rr = 1;
    @(negedge clk);
    tx_busy = 1'b1;
    c = 0; stray = 1'b0;
    while (err === 4'b0 && c < FRAME_TMO + 20) begin
      @(negedge clk); c++;
      if (done !== 4'b0) stray = 1'b1;
    end
    n_checks++;
    if ({err, grant} !== {4'b0001, 4'b0001})
      $display("FAIL frame_tmo_err: got err=%b grant=%b, need err=0001 grant=0001", err, grant);
    else n_pass++;
    n_checks++;
    if (c < FRAME_TMO || c > FRAME_TMO + 3)
      $display("FAIL frame_tmo_time: got err after %0d busy cycles, need %0d..%0d", c, FRAME_TMO, FRAME_TMO + 3);
    else n_pass++;
    req = 4'b0010;
    repeat (150) begin
      @(negedge clk);
      if (done !== 4'b0 || err !== 4'b0) stray = 1'b1;
    end
    n_checks++;
    if (stray || grant !== 4'b0 || signals !== 32'd0)
      $display("FAIL frame_tmo_hold: got stray=%0d grant=%b signals=%h, need 0/0000/0", stray, grant, signals);
    else n_pass++;
`ifdef TX_SCHED_STATS_EN
    n_checks++;
    if ({err_cnt, frame_cnt} !== {16'd1, 32'd0})
      $display("FAIL stats_after_err: got err_cnt=%0d frame_cnt=%0d, need 1 and 0", err_cnt, frame_cnt);
    else n_pass++;
`endif
    tx_busy = 1'b0;
    serve_frame(rr_pick(req, m_rr), 1, 6, "after_ftmo", w);
    n_checks++;
    if (w < IFG_CYCLES || w > IFG_CYCLES + 3)
      $display("FAIL frame_tmo_gap: got %0d cycles busy-fall to start, need %0d..%0d", w, IFG_CYCLES, IFG_CYCLES + 3);
    else n_pass++;
`ifdef TX_SCHED_STATS_EN
    n_checks++;
    if ({err_cnt, frame_cnt} !== {16'd1, 32'd1})
      $display("FAIL stats_after_done: got err_cnt=%0d frame_cnt=%0d, need 1 and 1", err_cnt, frame_cnt);
    else n_pass++;
`endif
    req = '0;
  endtask

  task automatic test_reset_midframe();
    int w; bit stray;
    do_reset();
    randomize_counts();
    req = 4'b0001;
    repeat (3) @(negedge clk);
    tx_busy = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({signals, sel, grant, done, err} !== 46'd0)
      $display("FAIL midreset_outputs: got signals=%h grant=%b done=%b err=%b, need all zero",
               signals, grant, done, err);
    else n_pass++;
    stray = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 4'b0 || err !== 4'b0) stray = 1'b1;
    end
    n_checks++;
    if (stray) $display("FAIL midreset_pulse: got done/err while in reset, need none");
    else n_pass++;
    rst = 1'b0; tx_busy = 1'b0; req = 4'b0010; m_rr = 0;
    serve_frame(rr_pick(req, m_rr), 2, 12, "post_reset", w);
    n_checks++;
    if (w !== 2) $display("FAIL post_reset_latency: got %0d cycles, need 2", w);
    else n_pass++;
    req = '0;
  endtask

  task automatic test_drop_after_start();
    int w;
    do_reset();
    randomize_counts();
    req = 4'b1000;
    w = 0;
    while (signals[0] !== 1'b1 && w < 10) begin @(negedge clk); w++; end
    n_checks++;
    if ({grant, 6'(w)} !== {4'b1000, 6'd2})
      $display("FAIL drop_grant: got grant=%b after %0d cycles, need 1000 after 2", grant, w);
    else n_pass++;
    @(negedge clk);
    req = 4'b0011;
    tx_busy = 1'b1;
    repeat (10) @(negedge clk);
    tx_busy = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({done, err} !== {4'b1000, 4'b0000})
      $display("FAIL drop_done: got done=%b err=%b, need done=1000 err=0000", done, err);
    else n_pass++;
    m_rr = 0;
    serve_frame(rr_pick(req, m_rr), 1, 4, "drop_next", w);
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_random();
    test_start_timeout();
    test_frame_timeout();
    test_reset_midframe();
    test_drop_after_start();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got no completion by 900us, need completion");
    $fatal(1);
  end

endmodule
